psum_accum_quant: RTL

PSUM_ACCUM_QUANT -- requirements
Module: psum_accum_quant

---
 rtl/psum_accum_quant.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/psum_accum_quant.sv
// psum_accum_quant: accumulates a group of partial-sum tiles per output lane,
// then shifts, clamps and packs each lane to 4 bits for the next layer.
// A completed group is held on act_out until downstream takes it.
module psum_accum_quant #(
    parameter int LANES  = 72,
    parameter int PSUM_W = 14
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      psum_valid,
    input  logic [LANES*PSUM_W-1:0]   psum_in,
    input  logic [3:0]                tile_num_cfg,
    input  logic [3:0]                shift_cfg,
    input  logic                      relu_en,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [LANES*4-1:0]        act_out,
    output logic                      busy,
    output logic                      err_drop
);

    // Four guard bits: 16 tiles of the most extreme 14b value still fit.
    localparam int ACC_W = PSUM_W + 4;

    localparam logic signed [ACC_W-1:0] C_ZERO  = '0;
    localparam logic signed [ACC_W-1:0] C_POS15 = ACC_W'(15);
    localparam logic signed [ACC_W-1:0] C_POS7  = ACC_W'(7);
    localparam logic signed [ACC_W-1:0] C_NEG8  = ACC_W'(-8);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [4:0]           r_cnt;
    logic [4:0]           w_cnt_nxt;
    logic [3:0]           r_num;
    logic [3:0]           r_shift;
    logic                 r_relu;
    logic                 r_out_valid;
    logic                 r_busy;
    logic                 r_err_drop;
    logic [LANES*4-1:0]   r_act;
    logic [LANES*4-1:0]   w_act_nxt;

    logic                 w_handshake;
    logic                 w_first;
    logic                 w_add;
    logic                 w_drop;
    logic                 w_last_add;
    logic                 w_done;
    logic [3:0]           w_shift_sel;
    logic                 w_relu_sel;

    // Arithmetic shift, then clamp to unsigned [0,15] or signed [-8,7].
    function automatic logic [3:0] f_quant(
        input logic signed [ACC_W-1:0] acc,
        input logic [3:0]              sh,
        input logic                    relu
    );
        logic signed [ACC_W-1:0] q;
        logic [3:0]              res;
        q = acc >>> sh;
        if (relu) begin
            if (q < C_ZERO)
                res = 4'd0;
            else if (q > C_POS15)
                res = 4'd15;
            else
                res = q[3:0];
        end else begin
            if (q > C_POS7)
                res = 4'h7;
            else if (q < C_NEG8)
                res = 4'h8;
            else
                res = q[3:0];
        end
        return res;
    endfunction

    // Event decode; clr masks every tile-related event.
    // HOLD always presents out_valid=1, so the handshake only needs the state.
    always_comb begin
        w_handshake = (r_state == S_HOLD) && out_ready;
        w_first     = !clr && psum_valid && ((r_state == S_IDLE) || w_handshake);
        w_add       = !clr && psum_valid && (r_state == S_ACCUM);
        w_drop      = !clr && psum_valid && (r_state == S_HOLD) && !out_ready;
        w_last_add  = w_add && (r_cnt == {1'b0, r_num});
        w_done      = (w_first && (tile_num_cfg == 4'd0)) || w_last_add;
        // A first tile that is also the last one quantizes with the live config.
        w_shift_sel = w_first ? shift_cfg : r_shift;
        w_relu_sel  = w_first ? relu_en   : r_relu;
    end

    // Next-state and tile-count logic; clr wins over every other event.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (clr) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 5'd0;
        end else if (w_first) begin
            w_cnt_nxt   = 5'd1;
            w_state_nxt = (tile_num_cfg == 4'd0) ? S_HOLD : S_ACCUM;
        end else if (w_add) begin
            w_cnt_nxt = r_cnt + 5'd1;
            if (w_last_add)
                w_state_nxt = S_HOLD;
        end else if (w_handshake) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 5'd0;
        end
    end

    // Per-lane accumulator and quantized result of the value about to be stored.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic signed [PSUM_W-1:0] w_psum;
        logic signed [ACC_W-1:0]  w_ext;
        logic signed [ACC_W-1:0]  w_acc_nxt;
        logic signed [ACC_W-1:0]  r_acc;

        assign w_psum    = psum_in[k*PSUM_W +: PSUM_W];
        assign w_ext     = {{(ACC_W-PSUM_W){w_psum[PSUM_W-1]}}, w_psum};
        assign w_acc_nxt = w_first ? w_ext : (r_acc + w_ext);
        assign w_act_nxt[k*4 +: 4] = f_quant(w_acc_nxt, w_shift_sel, w_relu_sel);

        // Load on the first tile of a group, add on every later one.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                r_acc <= '0;
            else if (w_first || w_add)
                r_acc <= w_acc_nxt;
        end
    end

    // State, count, captured config and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 5'd0;
            r_num       <= 4'd0;
            r_shift     <= 4'd0;
            r_relu      <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_err_drop  <= 1'b0;
            r_act       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_out_valid <= (w_state_nxt == S_HOLD);
            r_busy      <= (w_state_nxt != S_IDLE);
            if (w_drop)
                r_err_drop <= 1'b1;
            if (w_first) begin
                r_num   <= tile_num_cfg;
                r_shift <= shift_cfg;
                r_relu  <= relu_en;
            end
            if (w_done)
                r_act <= w_act_nxt;
        end
    end

    assign out_valid = r_out_valid;
    assign act_out   = r_act;
    assign busy      = r_busy;
    assign err_drop  = r_err_drop;

endmodule
